serial_adder_ctrl: RTL and testbench

//  Bit-serial adder stage wrapping one full-adder cell plus a carry register.

---
 rtl/serial_adder_ctrl.sv | 154 +++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder: one full-adder cell plus carry register behind valid/ready handshakes
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADD_SUB_EN
    ,
    input  logic             sub
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_out_q, sum_out_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;

    logic             bit_s;
    logic             bit_c;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] b_cap;
    logic             carry_cap;

    // Subtraction is A + ~B + 1, so cout = 1 means no borrow.
`ifdef SERIAL_ADD_SUB_EN
    assign b_cap     = sub ? ~b_in : b_in;
    assign carry_cap = sub ? 1'b1 : cin;
`else
    assign b_cap     = b_in;
    assign carry_cap = cin;
`endif

    always_comb begin
        bit_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        bit_c = (a_sh_q[0] & b_sh_q[0]) | (b_sh_q[0] & carry_q) | (carry_q & a_sh_q[0]);
        // Widened by one bit so the shift-in also works for WIDTH = 1.
        sum_ext = {bit_s, sum_sh_q};
    end

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_sh_d    = sum_sh_q;
        sum_out_d   = sum_out_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        cout_d      = cout_q;

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    a_sh_d     = a_in;
                    b_sh_d     = b_cap;
                    carry_d    = carry_cap;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                sum_sh_d = sum_ext[WIDTH:1];
                carry_d  = bit_c;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_out_d   = sum_ext[WIDTH:1];
                    cout_d      = bit_c;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d == SHIFT) || (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            sum_out_q   <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_sh_q    <= sum_sh_d;
            sum_out_q   <= sum_out_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cout_q      <= cout_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum_out   = sum_out_q;
    assign cout      = cout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl (WIDTH = 8)
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum_out;
    logic         cout;
    logic         busy;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .cout      (cout),
        .busy      (busy)
`ifdef SERIAL_ADD_SUB_EN
        ,
        .sub       (sub)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
        if (s) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b} + (W+1)'(c);
    endfunction

    task automatic pop_check(input string tag);
        logic [W:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_sum"}, 32'(sum_out), 32'(e[W-1:0]));
            check({tag, "_cout"}, 32'(cout), 32'(e[W]));
        end
    endtask

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_in_ready", 32'(in_ready), 32'd1);
        a_in = a;
        b_in = b;
        cin = c;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("in_ready_after_accept", 32'(in_ready), 32'd0);
    endtask

    task automatic finish_op(input string tag, input int hold);
        int cyc = 0;
        logic [W:0] e;
        while (!out_valid && cyc < W + 5) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(W));
        e = (exp_q.size() != 0) ? exp_q[0] : '0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a_in = 8'hC3;
            b_in = 8'h3C;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_sum"}, 32'(sum_out), 32'(e[W-1:0]));
            check({tag, "_hold_cout"}, 32'(cout), 32'(e[W]));
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        pop_check(tag);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_out_valid_clr"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
        check({tag, "_busy_clr"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

        // Reset held for three cycles.
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum_out), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        #1;
        check("in_ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("in_ready_after_release", 32'(in_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            accept(vecs[i].a, vecs[i].b, vecs[i].c);
            exp_q.push_back({vecs[i].co, vecs[i].s});
            finish_op($sformatf("vec%0d", i), 0);
        end

        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ra, rb;
            logic rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            accept(ra, rb, rc);
            exp_q.push_back(model(ra, rb, rc, 1'b0));
            finish_op($sformatf("rnd%0d", i), i % 3);
        end

        // Backpressure with in_valid pulses while in DONE.
        accept(8'h5A, 8'h33, 1'b0);
        a_in = 8'h11;
        b_in = 8'h22;
        cin = 1'b1;
        exp_q.push_back({1'b0, 8'h8D});
        finish_op("bp", 5);
        @(posedge clk); #1;
        check("bp_no_spurious_accept", 32'(busy), 32'd0);

        // Back-to-back issue interval with consumer always ready.
        begin
            int n = 0;
            int pops = 0;
            out_ready = 1'b1;
            accept(8'h21, 8'h43, 1'b1);
            exp_q.push_back({1'b0, 8'h65});
            while (!in_ready && n < W + 10) begin
                if (out_valid) begin
                    pop_check("b2b");
                    pops++;
                end
                @(posedge clk); #1;
                n++;
            end
            out_ready = 1'b0;
            check("b2b_interval", 32'(n), 32'(W + 1));
            check("b2b_pops", 32'(pops), 32'd1);
        end

        // Reset during SHIFT discards the operation.
        accept(8'hAA, 8'h55, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum_out), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < W + 4; i++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            check("midrst_no_out_valid", 32'(seen), 32'd0);
        end
        accept(8'h10, 8'h20, 1'b0);
        exp_q.push_back({1'b0, 8'h30});
        finish_op("post_rst", 0);

`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b1;
        accept(8'h05, 8'h07, 1'b0);
        sub = 1'b0;
        exp_q.push_back({1'b0, 8'hFE});
        finish_op("sub0", 0);
        sub = 1'b1;
        accept(8'h07, 8'h05, 1'b0);
        sub = 1'b0;
        exp_q.push_back({1'b1, 8'h02});
        finish_op("sub1", 1);
`endif

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
